// File: rtl/hs_math_seq_pkg.sv
// Shared types and helpers for the sequential math blocks (hs_math_seq_*).
package hs_math_seq_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } hs_div_state_e;

  // Iteration counter width for a WIDTH-bit divider.
  function automatic int div_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/hs_math_div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit, subtract the divisor if it fits.
module hs_math_div_step
  import hs_math_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             dividend_bit,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted_s;

  // Trial subtraction on a WIDTH+1 bit partial remainder; the modular WIDTH-bit difference is exact because the true result is below divisor.
  always_comb begin
    shifted_s = {rem_in, dividend_bit};
    rem_out   = shifted_s[WIDTH-1:0];
    q_bit     = 1'b0;
    if (shifted_s >= {1'b0, divisor}) begin
      rem_out = shifted_s[WIDTH-1:0] - divisor;
      q_bit   = 1'b1;
    end else begin
      rem_out = shifted_s[WIDTH-1:0];
      q_bit   = 1'b0;
    end
  end

endmodule

// File: rtl/hs_math_seq_div.sv
// Iterative unsigned divider, one quotient bit per cycle, valid/ready on both sides.
// Optional ceiling output enabled by defining HS_MATH_DIV_CEIL_EN.
module hs_math_seq_div
  import hs_math_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             out_div_by_zero
`ifdef HS_MATH_DIV_CEIL_EN
  ,
  output logic [WIDTH-1:0] out_ceil
`endif
);

  localparam int            CW        = div_cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  hs_div_state_e    state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] rem_next_s;
  logic             q_bit_s;
  logic [WIDTH-1:0] quot_next_s;

  assign in_ready    = (state_r == DIV_IDLE);
  // Quotient bits shift into the vacated low end of the dividend register.
  assign quot_next_s = {dvd_r[WIDTH-2:0], q_bit_s};

  hs_math_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in      (rem_r),
    .divisor     (dvs_r),
    .dividend_bit(dvd_r[WIDTH-1]),
    .rem_out     (rem_next_s),
    .q_bit       (q_bit_s)
  );

  // Control FSM, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= DIV_IDLE;
      cnt_r           <= {CW{1'b0}};
      dvd_r           <= {WIDTH{1'b0}};
      dvs_r           <= {WIDTH{1'b0}};
      rem_r           <= {WIDTH{1'b0}};
      out_valid       <= 1'b0;
      out_quotient    <= {WIDTH{1'b0}};
      out_remainder   <= {WIDTH{1'b0}};
      out_div_by_zero <= 1'b0;
`ifdef HS_MATH_DIV_CEIL_EN
      out_ceil        <= {WIDTH{1'b0}};
`endif
    end else begin
      case (state_r)
        DIV_IDLE: begin
          if (in_valid) begin
            dvd_r <= in_dividend;
            dvs_r <= in_divisor;
            rem_r <= {WIDTH{1'b0}};
            cnt_r <= {CW{1'b0}};
            if (in_divisor == {WIDTH{1'b0}}) begin
              state_r         <= DIV_DONE;
              out_valid       <= 1'b1;
              out_quotient    <= {WIDTH{1'b1}};
              out_remainder   <= in_dividend;
              out_div_by_zero <= 1'b1;
`ifdef HS_MATH_DIV_CEIL_EN
              out_ceil        <= {WIDTH{1'b1}};
`endif
            end else begin
              state_r <= DIV_BUSY;
            end
          end
        end
        DIV_BUSY: begin
          dvd_r <= quot_next_s;
          rem_r <= rem_next_s;
          if (cnt_r == LAST_ITER) begin
            state_r         <= DIV_DONE;
            cnt_r           <= {CW{1'b0}};
            out_valid       <= 1'b1;
            out_quotient    <= quot_next_s;
            out_remainder   <= rem_next_s;
            out_div_by_zero <= 1'b0;
`ifdef HS_MATH_DIV_CEIL_EN
            // A nonzero remainder guarantees the quotient is below all-ones, so this cannot wrap.
            out_ceil        <= quot_next_s + WIDTH'(rem_next_s != {WIDTH{1'b0}});
`endif
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DIV_DONE: begin
          if (out_ready) begin
            state_r   <= DIV_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state_r   <= DIV_IDLE;
          cnt_r     <= {CW{1'b0}};
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hs_math_seq_div.sv
// Self-checking bench for hs_math_seq_div (WIDTH=8): arithmetic reference model plus directed cases.
module tb_hs_math_seq_div;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] in_dividend = '0;
  logic [W-1:0] in_divisor = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_quotient;
  logic [W-1:0] out_remainder;
  logic         out_div_by_zero;
`ifdef HS_MATH_DIV_CEIL_EN
  logic [W-1:0] out_ceil;
`endif

  int n_chk = 0;
  int n_fail = 0;

  hs_math_seq_div #(.WIDTH(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_dividend    (in_dividend),
    .in_divisor     (in_divisor),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_quotient   (out_quotient),
    .out_remainder  (out_remainder),
    .out_div_by_zero(out_div_by_zero)
`ifdef HS_MATH_DIV_CEIL_EN
    ,
    .out_ceil       (out_ceil)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference arithmetic
  function automatic logic [W-1:0] m_quot(input int d, input int v);
    return (v == 0) ? W'((1 << W) - 1) : W'(d / v);
  endfunction
  function automatic logic [W-1:0] m_rem(input int d, input int v);
    return (v == 0) ? W'(d) : W'(d % v);
  endfunction
  function automatic logic [W-1:0] m_ceil(input int d, input int v);
    return (v == 0) ? W'((1 << W) - 1) : W'((d + v - 1) / v);
  endfunction

  // Transaction-level model: one op in flight, result visible from its due cycle until handshake.
  int       cyc = 0;
  int       due_m = 0;
  bit       busy_m = 1'b0;
  bit       chk_en = 1'b0;
  logic [W-1:0] p_q, p_r, p_c;
  logic         p_z;
  logic [W-1:0] e_q = '0, e_r = '0, e_c = '0;
  logic         e_z = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      busy_m = 1'b0;
      e_q = '0; e_r = '0; e_c = '0; e_z = 1'b0;
    end else if (busy_m) begin
      if (cyc >= due_m && out_ready) busy_m = 1'b0;
    end else if (in_valid) begin
      busy_m = 1'b1;
      p_q = m_quot(int'(in_dividend), int'(in_divisor));
      p_r = m_rem(int'(in_dividend), int'(in_divisor));
      p_c = m_ceil(int'(in_dividend), int'(in_divisor));
      p_z = (in_divisor == '0);
      due_m = cyc + ((in_divisor == '0) ? 1 : W + 1);
    end
    cyc++;
    if (busy_m && cyc >= due_m) begin
      e_q = p_q; e_r = p_r; e_c = p_c; e_z = p_z;
    end
    chk_en = 1'b1;
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", in_ready, !busy_m);
      check("out_valid", out_valid, busy_m && (cyc >= due_m));
      check("quotient", out_quotient, e_q);
      check("remainder", out_remainder, e_r);
      check("div_by_zero", out_div_by_zero, e_z);
`ifdef HS_MATH_DIV_CEIL_EN
      check("ceil", out_ceil, e_c);
`endif
    end
  end

  task automatic wait_valid(output int lat);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("valid_timeout", (lat < 40), 1);
  endtask

  task automatic run_op(input int d, input int v, input int eq, input int er, input int ez, input int ec);
    int lat;
    in_valid = 1'b1; in_dividend = W'(d); in_divisor = W'(v); out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_valid(lat);
    check($sformatf("lat_%0d_%0d", d, v), lat, (v == 0) ? 0 : W);
    check($sformatf("q_%0d_%0d", d, v), out_quotient, eq);
    check($sformatf("r_%0d_%0d", d, v), out_remainder, er);
    check($sformatf("dbz_%0d_%0d", d, v), out_div_by_zero, ez);
`ifdef HS_MATH_DIV_CEIL_EN
    check($sformatf("ceil_%0d_%0d", d, v), out_ceil, ec);
`endif
    @(negedge clk);
    check("idle_after_op", in_ready, 1);
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient", out_quotient, 0);
    check("rst_remainder", out_remainder, 0);
    rst = 1'b0;

    check("pin_q_100_7", m_quot(100, 7), 14);
    check("pin_r_100_7", m_rem(100, 7), 2);
    check("pin_c_100_7", m_ceil(100, 7), 15);
    check("pin_c_3_200", m_ceil(3, 200), 1);
    check("pin_q_42_0", m_quot(42, 0), 255);

    @(negedge clk);
    run_op(100, 7, 14, 2, 0, 15);
    run_op(255, 255, 1, 0, 0, 1);
    run_op(255, 1, 255, 0, 0, 255);
    run_op(3, 200, 0, 3, 0, 1);
    run_op(0, 9, 0, 0, 0, 0);
    run_op(42, 0, 255, 42, 1, 255);
    run_op(200, 128, 1, 72, 0, 2);

    // Back-pressure: result must hold while in_valid pulses are ignored.
    in_valid = 1'b1; in_dividend = 8'd100; in_divisor = 8'd7; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_quotient", out_quotient, 14);
      check("stall_remainder", out_remainder, 2);
      in_valid = (i % 2 == 0); in_dividend = 8'd9; in_divisor = 8'd1;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("stall_release_ready", in_ready, 1);
    check("stall_release_valid", out_valid, 0);
    check("stall_hold_q", out_quotient, 14);

    // Reset in the middle of an iteration.
    in_valid = 1'b1; in_dividend = 8'd200; in_divisor = 8'd3;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_quotient", out_quotient, 0);
    check("abort_remainder", out_remainder, 0);
    run_op(200, 3, 66, 2, 0, 67);

    // Random traffic with random back-pressure, checked by the model process.
    for (int i = 0; i < 3000; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_dividend = W'($urandom);
      case ($urandom_range(0, 5))
        0: in_divisor = '0;
        1: in_divisor = W'($urandom_range(1, 4));
        default: in_divisor = W'($urandom);
      endcase
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (W + 4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
